// File: rtl/service_gate_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : service_gate_sequencer_if
// Purpose  : Request/gate bundle between a transfer master and the sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface service_gate_sequencer_if #(
  parameter int NREG = 8
);
  logic            START;
  logic [NREG-1:0] RD_n;
  logic [NREG-1:0] WR_n;
  logic            CI_n;
  logic            GINH;
  logic [NREG-1:0] RG_n;
  logic [NREG-1:0] WG_n;
  logic [NREG-1:0] CG;
  logic            CI01_n;
  logic            BUSY;
  logic            DONE;
  logic            OVR;

  modport master (
    output START, RD_n, WR_n, CI_n, GINH,
    input  RG_n, WG_n, CG, CI01_n, BUSY, DONE, OVR
  );

  modport slave (
    input  START, RD_n, WR_n, CI_n, GINH,
    output RG_n, WG_n, CG, CI01_n, BUSY, DONE, OVR
  );
endinterface

`default_nettype wire

// File: rtl/service_gate_sequencer.sv
//------------------------------------------------------------------------------
// Module   : service_gate_sequencer
// Purpose  : Runs one CLEAR/READ/WRITE/FIN gate sequence per accepted START.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module service_gate_sequencer #(
  parameter int              NREG   = 8,
  parameter int              RD_CYC = 2,
  parameter logic [NREG-1:0] GMASK  = '0
) (
  input  wire logic               SIM_CLK,
  input  wire logic               SIM_RST,
  service_gate_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_CYC - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREG-1:0] rmask_q, rmask_d;
  logic [NREG-1:0] wmask_q, wmask_d;
  logic            ciff_q, ciff_d;
  logic            ovr_q, ovr_d;

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rmask_q <= '0;
      wmask_q <= '0;
      ciff_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      ciff_q  <= ciff_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: requests are captured only on the accepting edge in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    ciff_d  = ciff_q;
    ovr_d   = ovr_q;

    if (bus.START && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          rmask_d = ~bus.RD_n;
          wmask_d = ~bus.WR_n;
          ciff_d  = ~bus.CI_n;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = 4'd0;
        state_d = S_READ;
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WRITE: begin
        state_d = S_FIN;
      end
      S_FIN: begin
        ciff_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Gates decode from state and latched masks; GINH is the one live input,
  // so an inhibit raised during WRITE still suppresses the masked gates.
  always_comb begin
    bus.RG_n   = '1;
    bus.WG_n   = '1;
    bus.CG     = '0;
    bus.CI01_n = 1'b1;
    bus.DONE   = 1'b0;
    bus.BUSY   = (state_q != S_IDLE);
    bus.OVR    = ovr_q;

    case (state_q)
      S_CLEAR: begin
        bus.CG = wmask_q;
      end
      S_READ: begin
        bus.RG_n = ~rmask_q;
      end
      S_WRITE: begin
        bus.RG_n   = ~rmask_q;
        bus.WG_n   = ~(wmask_q & ~(GMASK & {NREG{bus.GINH}}));
        bus.CI01_n = ~ciff_q;
      end
      S_FIN: begin
        bus.DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_service_gate_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_service_gate_sequencer
// Purpose  : Random and directed transfers compared against a cycle-offset model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_service_gate_sequencer;

  localparam int         NREG   = 8;
  localparam int         RD_CYC = 2;
  localparam logic [7:0] GMASK  = 8'h04;
  localparam int         SEQ_LEN = RD_CYC + 3;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  // Model: a transfer is just "cycles since the accepting edge" plus the
  // request snapshot; every output follows from where that offset lies.
  bit         m_busy;
  int         m_off;
  logic [7:0] m_rm;
  logic [7:0] m_wm;
  logic       m_ci;
  bit         m_ovr;

  service_gate_sequencer_if #(.NREG(NREG)) bus ();

  service_gate_sequencer #(
    .NREG   (NREG),
    .RD_CYC (RD_CYC),
    .GMASK  (GMASK)
  ) dut (
    .SIM_CLK (clk),
    .SIM_RST (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_off  = 0;
    m_rm   = '0;
    m_wm   = '0;
    m_ci   = 1'b0;
    m_ovr  = 0;
  endtask

  task automatic model_edge(input logic s, input logic [7:0] rd, input logic [7:0] wr,
                            input logic c);
    if (m_busy) begin
      if (s) m_ovr = 1;
      if (m_off == SEQ_LEN) begin
        m_busy = 0;
        m_off  = 0;
      end else begin
        m_off++;
      end
    end else if (s) begin
      m_busy = 1;
      m_off  = 1;
      m_rm   = ~rd;
      m_wm   = ~wr;
      m_ci   = ~c;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_cg, e_rg, e_wg;
    logic       e_ci, e_done;
    bit         in_write;
    in_write = m_busy && (m_off == RD_CYC + 2);
    e_cg   = (m_busy && m_off == 1) ? m_wm : 8'h00;
    e_rg   = (m_busy && m_off >= 2 && m_off <= RD_CYC + 2) ? ~m_rm : 8'hFF;
    e_wg   = in_write ? ~(m_wm & ~(GMASK & {8{bus.GINH}})) : 8'hFF;
    e_ci   = in_write ? ~m_ci : 1'b1;
    e_done = m_busy && (m_off == SEQ_LEN);
    check_eq("CG",     32'(bus.CG),     32'(e_cg));
    check_eq("RG_n",   32'(bus.RG_n),   32'(e_rg));
    check_eq("WG_n",   32'(bus.WG_n),   32'(e_wg));
    check_eq("CI01_n", 32'(bus.CI01_n), 32'(e_ci));
    check_eq("BUSY",   32'(bus.BUSY),   32'(m_busy));
    check_eq("DONE",   32'(bus.DONE),   32'(e_done));
    check_eq("OVR",    32'(bus.OVR),    32'(m_ovr));
  endtask

  // Called at posedge+2; returns at the following posedge+2.
  task automatic step(input logic s, input logic [7:0] rd, input logic [7:0] wr,
                      input logic c, input logic g);
    bus.START = s;
    bus.RD_n  = rd;
    bus.WR_n  = wr;
    bus.CI_n  = c;
    bus.GINH  = g;
    @(posedge clk);
    model_edge(s, rd, wr, c);
    #1;
    check_outputs();
    #1;
  endtask

  // Asserting reset checks the asynchronous effect before any clock edge.
  task automatic apply_reset(input int hold);
    bus.START = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_outputs();
      #1;
    end
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_req();
    case ($urandom_range(0, 3))
      0:       rand_req = 8'hFF;
      1:       rand_req = ~(8'h01 << $urandom_range(0, 7));
      2:       rand_req = 8'h00;
      default: rand_req = 8'($urandom);
    endcase
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bus.START = 1'b0;
    bus.RD_n  = 8'hFF;
    bus.WR_n  = 8'hFF;
    bus.CI_n  = 1'b1;
    bus.GINH  = 1'b0;
    rst       = 1'b0;
    #1;
    apply_reset(2);
    #1;

    // Basic read/write transfer, then RD_n toggled during READ.
    step(1, 8'hFE, 8'hFD, 1, 0);
    step(0, 8'hFF, 8'hFF, 1, 0);
    step(0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 8'h00, 0, 0);
    step(0, 8'hFF, 8'hFF, 1, 0);
    step(0, 8'hFF, 8'hFF, 1, 0);

    // Inhibited write with carry-in, then the same un-inhibited.
    step(1, 8'hFF, 8'hFB, 0, 1);
    repeat (3) step(0, 8'hFF, 8'hFF, 1, 1);
    step(0, 8'hFF, 8'hFF, 1, 1);
    step(0, 8'hFF, 8'hFF, 1, 1);
    step(1, 8'hFF, 8'hFB, 0, 0);
    repeat (5) step(0, 8'hFF, 8'hFF, 1, 0);

    // All-zero masks still run the full sequence.
    step(1, 8'hFF, 8'hFF, 1, 0);
    repeat (5) step(0, 8'hFF, 8'hFF, 1, 0);

    // Overrun: START in READ and in FIN ignored, then back-to-back accept.
    step(1, 8'hF0, 8'h0F, 0, 0);
    step(0, 8'hFF, 8'hFF, 1, 0);
    step(1, 8'h00, 8'h00, 0, 0);
    step(0, 8'hFF, 8'hFF, 1, 0);
    step(0, 8'hFF, 8'hFF, 1, 0);
    step(1, 8'h00, 8'h00, 0, 0);
    step(1, 8'h7E, 8'hE7, 0, 0);
    repeat (6) step(0, 8'hFF, 8'hFF, 1, 0);

    // Reset mid-READ aborts and clears OVR.
    step(1, 8'hFE, 8'hFD, 0, 0);
    step(0, 8'hFF, 8'hFF, 1, 0);
    apply_reset(2);
    #1;
    step(1, 8'h3C, 8'hC3, 0, 1);
    repeat (6) step(0, 8'hFF, 8'hFF, 1, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset($urandom_range(1, 3));
        #1;
      end else begin
        step(($urandom_range(0, 3) == 0), rand_req(), rand_req(),
             1'($urandom), 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
